// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings, widths and write-slave FSM states
// Purpose: burst/response encodings and channel field widths shared by the
// AXI RAM write slave and its address generator (also usable by read slaves).
// Ports: none (package).
package axi_pkg;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  typedef enum logic [AXI_BURST_W-1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } axi_burst_e;

  typedef enum logic [AXI_RESP_W-1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational AXI next-beat address generator
// Purpose: given the current beat address and the burst attributes, produce
// the address of the following beat (FIXED / INCR / WRAP; reserved = INCR).
// Ports:
//   addr_i      current beat byte address
//   size_i      log2 bytes per beat
//   len_i       beats minus one (sets the WRAP container size)
//   burst_i     burst type
//   next_addr_o next beat byte address
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [AXI_SIZE_W-1:0]  size_i,
  input  logic [AXI_LEN_W-1:0]   len_i,
  input  logic [AXI_BURST_W-1:0] burst_i,
  output logic [ADDR_WIDTH-1:0]  next_addr_o
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] size_mask;
  logic [ADDR_WIDTH-1:0] cont_mask;

  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_i;
    size_mask = incr - ADDR_WIDTH'(1);
    // WRAP container is (len+1) beats of 2^size bytes
    cont_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    case (axi_burst_e'(burst_i))
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~cont_mask) | ((addr_i + incr) & cont_mask);
      // INCR and reserved: align the current beat down to size, then step
      default:     next_addr_o = (addr_i & ~size_mask) + incr;
    endcase
  end

endmodule

// File: rtl/axi_ram_wr.sv
// rtl/axi_ram_wr.sv - AXI4 write-channel slave driving a synchronous RAM write port
// Purpose: accepts one AW/W burst at a time, turns every accepted W beat into
// a zero-latency byte-strobed RAM write, and returns one B response per burst.
// Optional error checking (SLVERR/DECERR, suppressed writes) is enabled by
// defining AXI_RAM_WR_ERRCHK_EN; without it bresp is always OKAY.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   axi_slv_aw*           write address channel (id, addr, len, size, burst)
//   axi_slv_w*            write data channel (data, strb, last)
//   axi_slv_b*            write response channel (id, resp)
//   mem_we/addr/wdata/wstrb  RAM write port (word address, byte enables)
module axi_ram_wr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         axi_slv_awvalid,
  output logic                         axi_slv_awready,
  input  logic [ID_WIDTH-1:0]          axi_slv_awid,
  input  logic [ADDR_WIDTH-1:0]        axi_slv_awaddr,
  input  logic [AXI_LEN_W-1:0]         axi_slv_awlen,
  input  logic [AXI_SIZE_W-1:0]        axi_slv_awsize,
  input  logic [AXI_BURST_W-1:0]       axi_slv_awburst,
  input  logic                         axi_slv_wvalid,
  output logic                         axi_slv_wready,
  input  logic [DATA_WIDTH-1:0]        axi_slv_wdata,
  input  logic [DATA_WIDTH/8-1:0]      axi_slv_wstrb,
  input  logic                         axi_slv_wlast,
  output logic                         axi_slv_bvalid,
  input  logic                         axi_slv_bready,
  output logic [ID_WIDTH-1:0]          axi_slv_bid,
  output logic [AXI_RESP_W-1:0]        axi_slv_bresp,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [DATA_WIDTH/8-1:0]      mem_wstrb
);

  localparam int OFFS   = $clog2(DATA_WIDTH/8);
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  wr_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [AXI_LEN_W-1:0]   len_q, len_d;
  logic [AXI_SIZE_W-1:0]  size_q, size_d;
  logic [AXI_BURST_W-1:0] burst_q, burst_d;
  logic [AXI_LEN_W-1:0]   beat_q, beat_d;
  logic [AXI_RESP_W-1:0]  resp_q, resp_d;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic                   beat_last;
  logic [AXI_RESP_W-1:0]  beat_resp;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  assign beat_last = (beat_q == len_q);

`ifdef AXI_RAM_WR_ERRCHK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH) << OFFS;

  logic cfg_err_q, cfg_err_d;
  logic beat_oor;
  logic last_mism;

  // Beat response: out-of-range beats dominate (DECERR encodes above SLVERR)
  always_comb begin
    beat_oor  = ({1'b0, addr_q} >= MEM_BYTES);
    last_mism = (axi_slv_wlast != beat_last);
    if (beat_oor)
      beat_resp = RESP_DECERR;
    else if (cfg_err_q || last_mism)
      beat_resp = RESP_SLVERR;
    else
      beat_resp = RESP_OKAY;
  end

  always_comb begin
    cfg_err_d = cfg_err_q;
    if (state_q == ST_IDLE && axi_slv_awvalid) begin
      cfg_err_d = (axi_slv_awburst == BURST_RSVD)
               || (axi_slv_awburst == BURST_WRAP
                   && !(axi_slv_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
               || (axi_slv_awsize > AXI_SIZE_W'(OFFS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_err_d;
  end
`else
  assign beat_resp = RESP_OKAY;
`endif

  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    addr_d          = addr_q;
    len_d           = len_q;
    size_d          = size_q;
    burst_d         = burst_q;
    beat_d          = beat_q;
    resp_d          = resp_q;
    axi_slv_awready = 1'b0;
    axi_slv_wready  = 1'b0;
    axi_slv_bvalid  = 1'b0;
    mem_we          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        axi_slv_awready = 1'b1;
        if (axi_slv_awvalid) begin
          id_d    = axi_slv_awid;
          addr_d  = axi_slv_awaddr;
          len_d   = axi_slv_awlen;
          size_d  = axi_slv_awsize;
          burst_d = axi_slv_awburst;
          beat_d  = '0;
          resp_d  = RESP_OKAY;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        axi_slv_wready = 1'b1;
        if (axi_slv_wvalid) begin
          mem_we = (beat_resp == RESP_OKAY);
          addr_d = next_addr;
          beat_d = beat_q + AXI_LEN_W'(1);
          // Response encodings are ordered by severity, so keep the maximum
          if (beat_resp > resp_q) resp_d = beat_resp;
          // A missing wlast still closes the burst at beat len
          if (axi_slv_wlast || beat_last) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        axi_slv_bvalid = 1'b1;
        if (axi_slv_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign axi_slv_bid   = id_q;
  assign axi_slv_bresp = resp_q;
  assign mem_addr      = addr_q[OFFS +: MEM_AW];
  assign mem_wdata     = axi_slv_wdata;
  assign mem_wstrb     = axi_slv_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_axi_ram_wr.sv
// tb/tb_axi_ram_wr.sv - self-checking bench for axi_ram_wr (vector table + random bursts)
module tb_axi_ram_wr;

`ifdef AXI_RAM_WR_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif
  localparam int unsigned MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_ram_wr dut (
    .clk             (clk),
    .rst             (rst),
    .axi_slv_awvalid (awvalid),
    .axi_slv_awready (awready),
    .axi_slv_awid    (awid),
    .axi_slv_awaddr  (awaddr),
    .axi_slv_awlen   (awlen),
    .axi_slv_awsize  (awsize),
    .axi_slv_awburst (awburst),
    .axi_slv_wvalid  (wvalid),
    .axi_slv_wready  (wready),
    .axi_slv_wdata   (wdata),
    .axi_slv_wstrb   (wstrb),
    .axi_slv_wlast   (wlast),
    .axi_slv_bvalid  (bvalid),
    .axi_slv_bready  (bready),
    .axi_slv_bid     (bid),
    .axi_slv_bresp   (bresp),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte address of beat i, from the burst rules written as plain arithmetic
  function automatic int unsigned beat_addr(input int unsigned start, input int len,
                                            input int size, input int burst, input int i);
    int unsigned bytes, c, base;
    bytes = 1 << size;
    if (i == 0 || burst == 0) return start;
    if (burst == 2) begin
      c    = (len + 1) * bytes;
      base = start - (start % c);
      return base + ((start - base) + i * bytes) % c;
    end
    return (start / bytes) * bytes + i * bytes;
  endfunction

  // Runs one burst; wlast_at > len means wlast is never asserted
  task automatic run_burst(input logic [3:0] id, input int unsigned addr, input int len,
                           input int size, input int burst, input int wstrb_fix,
                           input int wlast_at, input int bdelay, input string tag,
                           output int nwr, output int first_ma, output int last_ma,
                           output int resp_o);
    int n, exp_resp, r;
    int unsigned a;
    bit wl, mism, cfgerr, we_exp;
    n        = (wlast_at < len) ? wlast_at : len;
    exp_resp = 0;
    nwr      = 0;
    first_ma = -1;
    last_ma  = -1;
    cfgerr   = (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15})) || (size > 2);

    @(posedge clk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len);
    awsize = 3'(size); awburst = 2'(burst);
    @(negedge clk);
    chk({tag, " awready idle"}, awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;

    for (int i = 0; i <= n; i++) begin
      a    = beat_addr(addr, len, size, burst, i);
      wl   = (i == wlast_at);
      mism = (wl != (i == len));
      if (!ERRCHK)                r = 0;
      else if (a >= MEM_BYTES)    r = 3;
      else if (cfgerr || mism)    r = 2;
      else                        r = 0;
      we_exp = (r == 0);
      if (r > exp_resp) exp_resp = r;
      wvalid = 1'b1;
      wdata  = $urandom;
      wstrb  = (wstrb_fix != 0) ? 4'(wstrb_fix) : 4'($urandom_range(0, 15));
      wlast  = wl;
      @(negedge clk);
      chk($sformatf("%s wready b%0d", tag, i), wready, 1);
      chk($sformatf("%s mem_we b%0d", tag, i), mem_we, we_exp);
      if (we_exp) begin
        chk($sformatf("%s mem_addr b%0d", tag, i), mem_addr, (a >> 2) % 1024);
        chk($sformatf("%s mem_wdata b%0d", tag, i), mem_wdata, wdata);
        chk($sformatf("%s mem_wstrb b%0d", tag, i), mem_wstrb, wstrb);
      end
      if (mem_we) begin
        nwr++;
        if (first_ma < 0) first_ma = int'(mem_addr);
        last_ma = int'(mem_addr);
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;

    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      chk($sformatf("%s bvalid hold%0d", tag, d), bvalid, 1);
      chk($sformatf("%s bid hold%0d", tag, d), bid, id);
      chk($sformatf("%s bresp hold%0d", tag, d), bresp, exp_resp);
      chk($sformatf("%s awready hold%0d", tag, d), awready, 0);
      chk($sformatf("%s wready resp%0d", tag, d), wready, 0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    chk({tag, " bvalid"}, bvalid, 1);
    chk({tag, " bid"}, bid, id);
    chk({tag, " bresp"}, bresp, exp_resp);
    chk({tag, " awready in B hs"}, awready, 0);
    resp_o = int'(bresp);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk({tag, " awready after B"}, awready, 1);
    chk({tag, " bvalid after B"}, bvalid, 0);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  id;
    int unsigned addr;
    int          len, size, burst, wstrb, wlast_at, bdelay;
    int          exp_nwr, exp_first, exp_last, exp_resp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int nwr, fm, lm, rs;
    rst = 1'b1; awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;

    vecs.push_back('{"single", 4'd5, 32'h10, 0, 2, 1, 'hF, 0, 0, 1, 4, 4, 0});
    vecs.push_back('{"incr4", 4'd1, 32'h100, 3, 2, 1, 'h3, 3, 0, 4, 'h40, 'h43, 0});
    vecs.push_back('{"wrap4", 4'd2, 32'h0C, 3, 2, 2, 0, 3, 0, 4, 3, 2, 0});
    vecs.push_back('{"fixed_bp5", 4'd3, 32'h20, 2, 2, 0, 0, 2, 5, 3, 8, 8, 0});
    vecs.push_back('{"incr_byte", 4'd4, 32'h13, 5, 0, 1, 0, 5, 1, 6, 4, 6, 0});
    vecs.push_back('{"incr_unal", 4'd6, 32'h1E, 2, 2, 1, 0, 2, 0, 3, 7, 9, 0});
    vecs.push_back('{"wrap2_half", 4'd10, 32'h6, 1, 1, 2, 0, 1, 0, 2, 1, 1, 0});
    vecs.push_back('{"early_last", 4'd7, 32'h200, 3, 2, 1, 0, 2, 0,
                     ERRCHK ? 2 : 3, 'h80, ERRCHK ? 'h81 : 'h82, ERRCHK ? 2 : 0});
    vecs.push_back('{"oor", 4'd8, 32'h1000, 0, 2, 1, 0, 0, 0,
                     ERRCHK ? 0 : 1, 0, 0, ERRCHK ? 3 : 0});
    vecs.push_back('{"no_last", 4'd9, 32'h40, 1, 2, 1, 0, 255, 0,
                     ERRCHK ? 1 : 2, 'h10, ERRCHK ? 'h10 : 'h11, ERRCHK ? 2 : 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst awready", awready, 1);
    chk("rst wready", wready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst bid", bid, 0);
    chk("rst bresp", bresp, 0);
    chk("rst mem_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wvalid = 1'b1;
    @(negedge clk);
    chk("idle no W accept", wready, 0);
    chk("idle no write", mem_we, 0);
    @(posedge clk); #1;
    wvalid = 1'b0;

    foreach (vecs[k]) begin
      run_burst(vecs[k].id, vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst,
                vecs[k].wstrb, vecs[k].wlast_at, vecs[k].bdelay, vecs[k].name,
                nwr, fm, lm, rs);
      chk({vecs[k].name, " nwrites"}, nwr, vecs[k].exp_nwr);
      if (vecs[k].exp_nwr > 0) begin
        chk({vecs[k].name, " first addr"}, fm, vecs[k].exp_first);
        chk({vecs[k].name, " last addr"}, lm, vecs[k].exp_last);
      end
      chk({vecs[k].name, " resp"}, rs, vecs[k].exp_resp);
    end

    // Reset after beat 1 of an 8-beat burst abandons it
    @(posedge clk); #1;
    awvalid = 1'b1; awid = 4'd3; awaddr = 32'h80; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF; wlast = 1'b0;
    @(negedge clk);
    chk("rstmid beat0 we", mem_we, 1);
    @(posedge clk); #1;
    wdata = $urandom;
    @(posedge clk); #1;
    wvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid bvalid", bvalid, 0);
    chk("rstmid wready", wready, 0);
    chk("rstmid awready", awready, 1);
    chk("rstmid mem_we", mem_we, 0);
    run_burst(4'd12, 32'h300, 3, 2, 1, 0, 3, 0, "post_rst", nwr, fm, lm, rs);
    chk("post_rst nwrites", nwr, 4);
    chk("post_rst first addr", fm, 'hC0);
    chk("post_rst resp", rs, 0);

    // Random bursts against the beat-level model
    for (int t = 0; t < 30; t++) begin
      int burst, len, size, wl_at, sel;
      int wrap_lens[4] = '{1, 3, 7, 15};
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 2);
      len   = (burst == 2) ? wrap_lens[$urandom_range(0, 3)] : $urandom_range(0, 15);
      sel   = $urandom_range(0, 7);
      if (sel == 0)      wl_at = $urandom_range(0, len);
      else if (sel == 1) wl_at = 255;
      else               wl_at = len;
      run_burst(4'($urandom), $urandom_range(0, 8191), len, size, burst, 0, wl_at,
                $urandom_range(0, 3), $sformatf("rnd%0d", t), nwr, fm, lm, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
